qspi_target: RTL and testbench
==============================

// Module: qspi_target
// PURPOSE
//  QSPI responder (flash-side) for the 1-bit-cmd / 4-bit-addr / dummy / 4-bit-data frame our initiator emits.
//  Shifts in the 8-bit command on io_in[0], then the address as 4-bit nibbles, counts dummy cycles, then
//  streams bytes fetched from a 1-cycle-latency synchronous memory port on io_out. One protocol bit cycle = one clk.
//  Used as the synthesizable flash model in cache integration benches and as the FPGA-side emulated flash.
// PARAMETERS
//  ADDR_W        32     address width; multiple of 4; ADDR_W/4 address nibble cycles
//  DUMMY_CYCLES  2      dummy cycles between address and data; must be >= 2 (elaboration assertion)
//  READ_CMD      8'h3B  command byte that starts a data-out phase
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous active-high reset
//  cs_n       in   1       chip select, active low, sampled on clk
//  io_in      in   4       sampled lines; cmd uses bit 0 only
//  io_out     out  4       data nibble driven to initiator
//  io_oe      out  1       high while io_out is driven
//  mem_req    out  1       one-cycle read strobe
//  mem_addr   out  ADDR_W  byte address, valid while mem_req
//  mem_rdata  in   8       read data, valid exactly 1 cycle after mem_req
//  cmd_valid  out  1       one-cycle pulse: command byte received
//  cmd_byte   out  8       last received command, held until next cmd_valid
// BEHAVIOUR
//  - Reset: io_out=0, io_oe=0, mem_req=0, mem_addr=0, cmd_valid=0, cmd_byte=0; state=SKIP.
//  - Bit cycle k: k-th posedge with cs_n low in a frame (k=0 at first posedge cs_n sampled low).
//  - States: IDLE, CMD, ADDR, DUMMY, DATA, SKIP.
//    IDLE: cs_n low -> sample io_in[0] as cmd[7] at k=0, go CMD.
//    CMD: k=1..7 shift io_in[0], MSB first; at k=7 cmd complete: cmd_valid pulses the following cycle,
//      cmd_byte updates; ==READ_CMD -> ADDR, else -> SKIP.
//    ADDR: k=8..8+ADDR_W/4-1 shift io_in[3:0], MSB nibble first -> DUMMY.
//    DUMMY: DUMMY_CYCLES cycles; io_in ignored.
//    DATA: io_oe=1; byte at addr A: high nibble sampled by initiator at k=D, low nibble at k=D+1, D=8+ADDR_W/4+DUMMY_CYCLES;
//      then A+1, A+2, ... until cs_n high. io_out/io_oe registered: nibble for cycle k loaded at posedge k-1.
//    SKIP: io_oe=0, no mem traffic; leave to IDLE only when cs_n sampled high.
//  - Fetch: mem_req for byte n asserted in the cycle following posedge D-3+2n, mem_addr=A+n; mem_rdata captured
//    at the next posedge into a 1-byte buffer; buffer loaded into the shifter at posedge D-2+2n (unconditional).
//  - Address increment modulo 2^ADDR_W: all-ones wraps to 0 without error.
//  - cs_n sampled high in any state -> IDLE at that posedge; io_oe=0 and mem_req=0 from that edge; partial
//    cmd/addr discarded; an in-flight mem_rdata is dropped; no cmd_valid for a partial command.
//  - cs_n high-to-low with no idle cycle between frames is legal: one sampled-high cycle suffices.
//  - rst mid-frame -> SKIP; target ignores the rest of that frame and resyncs on next cs_n high.
//  - Non-read command: only cmd_valid/cmd_byte observable; io_oe stays 0.
// STRUCTURE
//  - qspi_pkg: READ_CMD default constant, qspi_state_t enum, CMD_BITS=8 localparam (shared with the initiator).
//  - Sub-module qspi_shift_in #(SIZE, IN_SIZE): shift-in register with done counter; one instance for cmd
//    (8,1), one for address (ADDR_W,4). Dummy counter, fetch buffer and data shifter live in qspi_target.
// TESTING
//  - Read: cmd 0x3B, addr 0x0000_0010, mem[0x10..0x12]=A5,3C,FF -> io_out 0xA,0x5,0x3,0xC,0xF,0xF from k=18; io_oe low before k=18.
//  - Non-read cmd 0x05 + 8 cycles -> cmd_valid one pulse, cmd_byte=0x05, io_oe=0, mem_req never high.
//  - Wrap: addr 0xFFFF_FFFF, 2 bytes -> mem_addr 0xFFFF_FFFF then 0x0000_0000, data stream uninterrupted.
//  - Abort: cs_n high at k=12 -> no mem_req, state IDLE; next frame cmd 0x3B addr 0x4 reads mem[4] correctly.
//  - Reset at k=20 of a read -> io_oe=0 next edge; cs_n held low 10 more cycles -> no output; frame after cs_n high works.
//  - Back-to-back frames, cs_n high for exactly 1 cycle -> both reads return correct data; cmd_valid pulses twice.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared QSPI frame definitions used by the flash-side target and the initiator.
package qspi_pkg;

  localparam int         CMD_BITS         = 8;
  localparam logic [7:0] READ_CMD_DEFAULT = 8'h3B;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_SKIP  = 3'd5
  } qspi_state_t;

endpackage

// File: rtl/qspi_if.sv
// QSPI pin bundle between initiator (master) and flash-side target (slave).
interface qspi_if;

  logic       cs_n;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic       io_oe;

  modport master (
    output cs_n,
    output io_in,
    input  io_out,
    input  io_oe
  );

  modport slave (
    input  cs_n,
    input  io_in,
    output io_out,
    output io_oe
  );

endinterface

// File: rtl/qspi_shift_in.sv
// MSB-first shift-in register; next_o/done_o expose the completed word on the edge
// that shifts in its final beat.
module qspi_shift_in
  import qspi_pkg::*;
#(
  parameter int SIZE    = CMD_BITS,
  parameter int IN_SIZE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [IN_SIZE-1:0] in_i,
  output logic [SIZE-1:0]    next_o,
  output logic               done_o
);

  localparam int BEATS = SIZE / IN_SIZE;
  localparam int CNT_W = $clog2(BEATS + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign done_o = en_i && (cnt_q == CNT_W'(BEATS - 1));

  // Beat counter: restarts on frame end and after each completed word.
  always_comb begin
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (done_o) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  if (SIZE > IN_SIZE) begin : g_shift
    logic [SIZE-IN_SIZE-1:0] data_q;

    assign next_o = {data_q, in_i};

    // Only the low bits survive: the top beat falls off when the word completes.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= {(SIZE-IN_SIZE){1'b0}};
      end else if (en_i) begin
        data_q <= next_o[SIZE-IN_SIZE-1:0];
      end else begin
        data_q <= data_q;
      end
    end
  end else begin : g_pass
    assign next_o = in_i;
  end

endmodule

// File: rtl/qspi_target.sv
// Flash-side QSPI responder: 1-bit command, 4-bit address, dummy cycles, then a
// nibble stream fed from a 1-cycle-latency synchronous byte memory.
module qspi_target
  import qspi_pkg::*;
#(
  parameter int         ADDR_W       = 32,
  parameter int         DUMMY_CYCLES = 2,
  parameter logic [7:0] READ_CMD     = READ_CMD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  qspi_if.slave             qspi,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              cmd_valid_o,
  output logic [7:0]        cmd_byte_o
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_CMD   = ST_CMD;
  localparam logic [2:0] S_ADDR  = ST_ADDR;
  localparam logic [2:0] S_DUMMY = ST_DUMMY;
  localparam logic [2:0] S_DATA  = ST_DATA;
  localparam logic [2:0] S_SKIP  = ST_SKIP;
  localparam int         DCNT_W  = $clog2(DUMMY_CYCLES + 1);

  if ((DUMMY_CYCLES < 2) || (ADDR_W < 4) || ((ADDR_W % 4) != 0)) begin : g_param_check
    $error("qspi_target: DUMMY_CYCLES must be >= 2 and ADDR_W a non-zero multiple of 4");
  end

  logic [2:0]        state_q,     state_d;
  logic [DCNT_W-1:0] dcnt_q,      dcnt_d;
  logic              mem_req_q,   mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic              rvalid_q,    rvalid_d;
  logic [3:0]        lo_q,        lo_d;
  logic [3:0]        io_out_q,    io_out_d;
  logic              io_oe_q,     io_oe_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        cmd_byte_q,  cmd_byte_d;

  logic              frame_s;
  logic              cmd_en_s;
  logic              cmd_done_s;
  logic [7:0]        cmd_next_s;
  logic              addr_en_s;
  logic              addr_done_s;
  logic [ADDR_W-1:0] addr_next_s;
  logic              fetch_start_s;
  logic              byte_arr_s;

  assign frame_s   = !qspi.cs_n;
  assign cmd_en_s  = frame_s && ((state_q == S_IDLE) || (state_q == S_CMD));
  assign addr_en_s = frame_s && (state_q == S_ADDR);

  qspi_shift_in #(.SIZE(CMD_BITS), .IN_SIZE(1)) u_cmd_shift (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (qspi.cs_n),
    .en_i   (cmd_en_s),
    .in_i   (qspi.io_in[0]),
    .next_o (cmd_next_s),
    .done_o (cmd_done_s)
  );

  qspi_shift_in #(.SIZE(ADDR_W), .IN_SIZE(4)) u_addr_shift (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (qspi.cs_n),
    .en_i   (addr_en_s),
    .in_i   (qspi.io_in),
    .next_o (addr_next_s),
    .done_o (addr_done_s)
  );

  // First fetch lands three edges before the first data sample; with two dummy
  // cycles that is the edge completing the address.
  assign fetch_start_s = (DUMMY_CYCLES == 2) ? addr_done_s :
                         ((state_q == S_DUMMY) && (dcnt_q == DCNT_W'(DUMMY_CYCLES - 3)));
  // Read data arriving is also the moment to request the following byte.
  assign byte_arr_s    = rvalid_q && ((state_q == S_DUMMY) || (state_q == S_DATA));

  // Next-state logic for frame sequencing, fetch pipeline and nibble output.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    rvalid_d    = 1'b0;
    lo_d        = lo_q;
    io_out_d    = io_out_q;
    io_oe_d     = io_oe_q;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    if (qspi.cs_n) begin
      state_d  = S_IDLE;
      dcnt_d   = {DCNT_W{1'b0}};
      io_out_d = 4'h0;
      io_oe_d  = 1'b0;
    end else begin
      rvalid_d  = mem_req_q;
      mem_req_d = fetch_start_s || byte_arr_s;
      if (byte_arr_s) begin
        mem_addr_d = mem_addr_q + ADDR_W'(1);
        io_out_d   = mem_rdata_i[7:4];
        lo_d       = mem_rdata_i[3:0];
        io_oe_d    = 1'b1;
      end else if (io_oe_q) begin
        io_out_d = lo_q;
      end else begin
        io_out_d = 4'h0;
      end
      case (state_q)
        S_IDLE: begin
          state_d = S_CMD;
        end
        S_CMD: begin
          if (cmd_done_s) begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = cmd_next_s;
            state_d     = (cmd_next_s == READ_CMD) ? S_ADDR : S_SKIP;
          end else begin
            state_d = S_CMD;
          end
        end
        S_ADDR: begin
          if (addr_done_s) begin
            mem_addr_d = addr_next_s;
            dcnt_d     = {DCNT_W{1'b0}};
            state_d    = S_DUMMY;
          end else begin
            state_d = S_ADDR;
          end
        end
        S_DUMMY: begin
          if (dcnt_q == DCNT_W'(DUMMY_CYCLES - 1)) begin
            state_d = S_DATA;
          end else begin
            dcnt_d = dcnt_q + DCNT_W'(1);
          end
        end
        S_DATA: begin
          state_d = S_DATA;
        end
        S_SKIP: begin
          state_d = S_SKIP;
        end
        default: begin
          state_d = S_SKIP;
        end
      endcase
    end
  end

  // State and output registers; reset parks in SKIP until the frame ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SKIP;
      dcnt_q      <= {DCNT_W{1'b0}};
      mem_req_q   <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      rvalid_q    <= 1'b0;
      lo_q        <= 4'h0;
      io_out_q    <= 4'h0;
      io_oe_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      rvalid_q    <= rvalid_d;
      lo_q        <= lo_d;
      io_out_q    <= io_out_d;
      io_oe_q     <= io_oe_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
    end
  end

  assign qspi.io_out = io_out_q;
  assign qspi.io_oe  = io_oe_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_byte_o  = cmd_byte_q;

endmodule

// File: tb/tb_qspi_target.sv
// Directed bench for qspi_target: acts as initiator and as the synchronous memory.
module tb_qspi_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_rdata_i;
  logic        cmd_valid_o;
  logic [7:0]  cmd_byte_o;

  qspi_if bus ();

  qspi_target dut (
    .clk         (clk),
    .rst         (rst),
    .qspi        (bus),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .cmd_valid_o (cmd_valid_o),
    .cmd_byte_o  (cmd_byte_o)
  );

  always #5 clk = ~clk;

  int          n_run  = 0;
  int          n_fail = 0;
  int          cv_count;
  int          req_count;
  int          oe_count;
  logic [31:0] req_q[$];
  logic [7:0]  mem [256];

  // Memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_req_o) mem_rdata_i <= mem[mem_addr_o[7:0]];
  end

  // Event monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (cmd_valid_o) cv_count++;
    if (bus.io_oe) oe_count++;
    if (mem_req_o) begin
      req_count++;
      req_q.push_back(mem_addr_o);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] cmd);
    bus.cs_n = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      bus.io_in = {3'b000, cmd[i]};
      step();
    end
  endtask

  task automatic send_addr(input logic [31:0] a);
    for (int i = 7; i >= 0; i--) begin
      bus.io_in = a[i*4 +: 4];
      step();
    end
  endtask

  // Full read frame of n nibbles; ends with exactly one cs_n-high edge.
  task automatic read_frame(input logic [31:0] addr, input int n, output logic [31:0] nibs,
                            output logic hdr_oe, output logic data_oe, output logic req15,
                            output logic post_oe);
    nibs     = 32'h0;
    data_oe  = 1'b1;
    oe_count = 0;
    send_cmd(8'h3B);
    send_addr(addr);
    req15     = mem_req_o;
    bus.io_in = 4'h0;
    step();
    step();
    hdr_oe = (oe_count != 0);
    for (int i = 0; i < n; i++) begin
      nibs = {nibs[27:0], bus.io_out};
      if (!bus.io_oe) data_oe = 1'b0;
      step();
    end
    bus.cs_n = 1'b1;
    step();
    post_oe = bus.io_oe;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.cs_n = 1'b1; bus.io_in = 4'h0;
    step(); step();
    n_run++; if (bus.io_out !== 4'h0) begin n_fail++; $display("FAIL reset_io_out: got %h expected %h", bus.io_out, 4'h0); end
    n_run++; if (bus.io_oe !== 1'b0) begin n_fail++; $display("FAIL reset_io_oe: got %b expected %b", bus.io_oe, 1'b0); end
    n_run++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected %b", mem_req_o, 1'b0); end
    n_run++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected %h", mem_addr_o, 32'h0); end
    n_run++; if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b expected %b", cmd_valid_o, 1'b0); end
    n_run++; if (cmd_byte_o !== 8'h00) begin n_fail++; $display("FAIL reset_cmd_byte: got %h expected %h", cmd_byte_o, 8'h00); end
    // Reset leaves the target in SKIP: a frame already in progress is ignored.
    bus.cs_n = 1'b0;
    step();
    rst = 1'b0;
    cv_count = 0;
    send_cmd(8'h3B);
    n_run++; if (cv_count !== 0) begin n_fail++; $display("FAIL reset_skip_cmd_valid: got %0d expected %0d", cv_count, 0); end
    bus.cs_n = 1'b1;
    step();
  endtask

  task automatic test_read();
    logic [31:0] nibs;
    logic hdr_oe, data_oe, req15, post_oe;
    cv_count = 0;
    req_q.delete();
    read_frame(32'h0000_0010, 6, nibs, hdr_oe, data_oe, req15, post_oe);
    n_run++; if (nibs[23:0] !== 24'hA53CFF) begin n_fail++; $display("FAIL read_nibbles: got %h expected %h", nibs[23:0], 24'hA53CFF); end
    n_run++; if (hdr_oe !== 1'b0) begin n_fail++; $display("FAIL read_oe_before_data: got %b expected %b", hdr_oe, 1'b0); end
    n_run++; if (data_oe !== 1'b1) begin n_fail++; $display("FAIL read_oe_during_data: got %b expected %b", data_oe, 1'b1); end
    n_run++; if (req15 !== 1'b1) begin n_fail++; $display("FAIL read_first_req_timing: got %b expected %b", req15, 1'b1); end
    n_run++;
    if (req_q.size() == 0) begin
      n_fail++; $display("FAIL read_first_req_addr: got no request expected %h", 32'h10);
    end else if (req_q[0] !== 32'h0000_0010) begin
      n_fail++; $display("FAIL read_first_req_addr: got %h expected %h", req_q[0], 32'h10);
    end
    n_run++; if (post_oe !== 1'b0) begin n_fail++; $display("FAIL read_oe_after_cs: got %b expected %b", post_oe, 1'b0); end
    n_run++; if (cv_count !== 1) begin n_fail++; $display("FAIL read_cmd_valid_count: got %0d expected %0d", cv_count, 1); end
    n_run++; if (cmd_byte_o !== 8'h3B) begin n_fail++; $display("FAIL read_cmd_byte: got %h expected %h", cmd_byte_o, 8'h3B); end
  endtask

  task automatic test_non_read();
    cv_count = 0; req_count = 0; oe_count = 0;
    send_cmd(8'h05);
    n_run++; if (cmd_valid_o !== 1'b1) begin n_fail++; $display("FAIL nonread_pulse_high: got %b expected %b", cmd_valid_o, 1'b1); end
    n_run++; if (cmd_byte_o !== 8'h05) begin n_fail++; $display("FAIL nonread_cmd_byte: got %h expected %h", cmd_byte_o, 8'h05); end
    for (int i = 0; i < 8; i++) begin
      bus.io_in = 4'(i * 5 + 3);
      step();
      if (i == 0) begin
        n_run++; if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL nonread_pulse_low: got %b expected %b", cmd_valid_o, 1'b0); end
      end
    end
    bus.cs_n = 1'b1;
    step();
    n_run++; if (cv_count !== 1) begin n_fail++; $display("FAIL nonread_cmd_valid_count: got %0d expected %0d", cv_count, 1); end
    n_run++; if (oe_count !== 0) begin n_fail++; $display("FAIL nonread_io_oe: got %0d expected %0d", oe_count, 0); end
    n_run++; if (req_count !== 0) begin n_fail++; $display("FAIL nonread_mem_req: got %0d expected %0d", req_count, 0); end
  endtask

  task automatic test_wrap();
    logic [31:0] nibs;
    logic hdr_oe, data_oe, req15, post_oe;
    req_q.delete();
    read_frame(32'hFFFF_FFFF, 4, nibs, hdr_oe, data_oe, req15, post_oe);
    n_run++; if (nibs[15:0] !== 16'h817E) begin n_fail++; $display("FAIL wrap_nibbles: got %h expected %h", nibs[15:0], 16'h817E); end
    n_run++; if (data_oe !== 1'b1) begin n_fail++; $display("FAIL wrap_oe_continuous: got %b expected %b", data_oe, 1'b1); end
    n_run++;
    if (req_q.size() < 2) begin
      n_fail++; $display("FAIL wrap_req_addrs: got %0d requests expected at least %0d", req_q.size(), 2);
    end else if ({req_q[0], req_q[1]} !== 64'hFFFF_FFFF_0000_0000) begin
      n_fail++; $display("FAIL wrap_req_addrs: got %h %h expected %h %h", req_q[0], req_q[1], 32'hFFFF_FFFF, 32'h0);
    end
  endtask

  task automatic test_abort();
    logic [31:0] nibs;
    logic hdr_oe, data_oe, req15, post_oe;
    cv_count = 0; req_count = 0;
    // Partial command: four bits then cs_n high.
    bus.cs_n = 1'b0;
    for (int i = 7; i >= 4; i--) begin
      bus.io_in = {3'b000, 8'h3B >> i};
      step();
    end
    bus.cs_n = 1'b1;
    step();
    n_run++; if (cv_count !== 0) begin n_fail++; $display("FAIL abort_partial_cmd_valid: got %0d expected %0d", cv_count, 0); end
    // Full command, address cut off at k=12.
    send_cmd(8'h3B);
    for (int i = 0; i < 4; i++) begin
      bus.io_in = 4'h0;
      step();
    end
    bus.cs_n = 1'b1;
    step();
    n_run++; if (bus.io_oe !== 1'b0) begin n_fail++; $display("FAIL abort_io_oe: got %b expected %b", bus.io_oe, 1'b0); end
    step(); step(); step();
    n_run++; if (req_count !== 0) begin n_fail++; $display("FAIL abort_mem_req: got %0d expected %0d", req_count, 0); end
    read_frame(32'h0000_0004, 2, nibs, hdr_oe, data_oe, req15, post_oe);
    n_run++; if (nibs[7:0] !== 8'h5A) begin n_fail++; $display("FAIL abort_next_read: got %h expected %h", nibs[7:0], 8'h5A); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] nibs;
    logic hdr_oe, data_oe, req15, post_oe;
    logic [7:0] junk;
    send_cmd(8'h3B);
    send_addr(32'h0000_0010);
    bus.io_in = 4'h0;
    step(); step(); step(); step();
    n_run++; if (bus.io_out !== 4'h3) begin n_fail++; $display("FAIL rstmid_pre_nibble: got %h expected %h", bus.io_out, 4'h3); end
    rst = 1'b1;
    step();
    n_run++; if (bus.io_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_io_oe: got %b expected %b", bus.io_oe, 1'b0); end
    rst = 1'b0;
    cv_count = 0; req_count = 0; oe_count = 0;
    junk = 8'h3B;
    for (int i = 0; i < 10; i++) begin
      bus.io_in = (i < 8) ? {3'b000, junk[7 - i]} : 4'hF;
      step();
    end
    n_run++; if (oe_count !== 0) begin n_fail++; $display("FAIL rstmid_no_output: got %0d expected %0d", oe_count, 0); end
    n_run++; if (req_count !== 0) begin n_fail++; $display("FAIL rstmid_no_req: got %0d expected %0d", req_count, 0); end
    n_run++; if (cv_count !== 0) begin n_fail++; $display("FAIL rstmid_no_cmd: got %0d expected %0d", cv_count, 0); end
    bus.cs_n = 1'b1;
    step();
    read_frame(32'h0000_0011, 2, nibs, hdr_oe, data_oe, req15, post_oe);
    n_run++; if (nibs[7:0] !== 8'h3C) begin n_fail++; $display("FAIL rstmid_next_read: got %h expected %h", nibs[7:0], 8'h3C); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] nibs_a, nibs_b;
    logic hdr_oe, data_oe, req15, post_a, post_b;
    cv_count = 0;
    read_frame(32'h0000_0010, 2, nibs_a, hdr_oe, data_oe, req15, post_a);
    read_frame(32'h0000_0020, 4, nibs_b, hdr_oe, data_oe, req15, post_b);
    n_run++; if (nibs_a[7:0] !== 8'hA5) begin n_fail++; $display("FAIL b2b_first_read: got %h expected %h", nibs_a[7:0], 8'hA5); end
    n_run++; if (nibs_b[15:0] !== 16'hC396) begin n_fail++; $display("FAIL b2b_second_read: got %h expected %h", nibs_b[15:0], 16'hC396); end
    n_run++; if (post_a !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_io_oe: got %b expected %b", post_a, 1'b0); end
    n_run++; if (cv_count !== 2) begin n_fail++; $display("FAIL b2b_cmd_valid_count: got %0d expected %0d", cv_count, 2); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C; mem[8'h12] = 8'hFF;
    mem[8'hFF] = 8'h81; mem[8'h00] = 8'h7E;
    mem[8'h04] = 8'h5A;
    mem[8'h20] = 8'hC3; mem[8'h21] = 8'h96;
    cv_count = 0; req_count = 0; oe_count = 0;
    rst = 1'b1; bus.cs_n = 1'b1; bus.io_in = 4'h0;
    test_reset();
    test_read();
    test_non_read();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
